move_dispatch_queue: RTL and testbench



---
 rtl/move_dispatch_queue_pkg.sv | 20 ++
 rtl/move_dispatch_queue_if.sv | 23 ++
 rtl/move_dispatch_queue_fifo.sv | 53 +++++
 rtl/move_dispatch_queue.sv | 130 +++++++++++++
 tb/tb_move_dispatch_queue.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/move_dispatch_queue_pkg.sv
// move_dispatch_queue_pkg: move codes, slot geometry and FSM state types shared across the cube-solver datapath
package move_dispatch_queue_pkg;
  localparam int SLOT_W = 4;
  localparam int INV_BIT = 0;
  localparam int FACE_LSB = 1;
  localparam int FACE_MSB = 3;
  typedef enum logic [SLOT_W-1:0] {
    PAD = 4'd0,
    R = 4'd2, RI = 4'd3, U = 4'd4, UI = 4'd5, F = 4'd6, FI = 4'd7,
    L = 4'd8, LI = 4'd9, B = 4'd10, BI = 4'd11, D = 4'd12, DI = 4'd13
  } move_e;
  typedef enum logic {L_IDLE, L_UNPACK} load_state_e;
  typedef enum logic [2:0] {D_WAIT, D_ISSUE, D_BUSY, D_SETTLE, D_DONE} disp_state_e;
  function automatic logic is_legal(input logic [SLOT_W-1:0] c);
    return c >= 4'd2 && c <= 4'd13;
  endfunction
  function automatic logic is_bad(input logic [SLOT_W-1:0] c);
    return c == 4'd1 || c >= 4'd14;
  endfunction
endpackage

// File: rtl/move_dispatch_queue_if.sv
// move_dispatch_queue_if: load bus, stepper handshake and display status between solver, queue and stepper
interface move_dispatch_queue_if import move_dispatch_queue_pkg::*; #(parameter int SLOTS = 50);
  logic                     load_valid;
  logic [SLOT_W*SLOTS-1:0]  load_moves;
  logic                     load_ready;
  logic                     seq_complete;
  logic [SLOT_W-1:0]        next_move;
  logic                     move_start;
  logic                     move_done;
  logic [7:0]               num_moves;
  logic [7:0]               curr_step;
  logic                     seq_done;
  logic                     overflow;
  logic                     bad_code;
  modport master (
    output load_valid, load_moves, seq_complete, move_done,
    input  load_ready, next_move, move_start, num_moves, curr_step, seq_done, overflow, bad_code
  );
  modport slave (
    input  load_valid, load_moves, seq_complete, move_done,
    output load_ready, next_move, move_start, num_moves, curr_step, seq_done, overflow, bad_code
  );
endinterface

// File: rtl/move_dispatch_queue_fifo.sv
// move_fifo: DEPTH x 4 synchronous FIFO with head pop and tail peek/pop for move cancellation
module move_fifo import move_dispatch_queue_pkg::*; #(
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clock_25mhz,
  input  logic              reset,
  input  logic              push,
  input  logic [SLOT_W-1:0] push_data,
  input  logic              pop,
  input  logic              pop_tail,
  output logic [SLOT_W-1:0] head,
  output logic [SLOT_W-1:0] tail,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [SLOT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop, do_pop_tail;
  // pointer and occupancy update; a head pop and tail pop never both take the last entry
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    do_pop_tail = pop_tail && !empty && !(do_pop && count_q == CW'(1));
    wr_ptr_d = wr_ptr_q + AW'(do_push) - AW'(do_pop_tail);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop) - CW'(do_pop_tail);
  end
  // state registers
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage write
  always_ff @(posedge clock_25mhz) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end
  assign head = mem[rd_ptr_q];
  assign tail = mem[wr_ptr_q - AW'(1)];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/move_dispatch_queue.sv
// move_dispatch_queue: unpacks solver move batches into a FIFO and dispatches them to the stepper; MOVE_CANCEL_EN merges inverse pairs at the tail
module move_dispatch_queue import move_dispatch_queue_pkg::*; #(
  parameter int DEPTH = 128,
  parameter int SETTLE_CYCLES = 250000,
  parameter int SLOTS = 50
) (
  input logic clock_25mhz,
  input logic reset,
  move_dispatch_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SLW = $clog2(SLOTS);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);
`ifdef MOVE_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif
  load_state_e l_state_q, l_state_d;
  disp_state_e d_state_q, d_state_d;
  logic [SLOT_W*SLOTS-1:0] word_q, word_d;
  logic [SLW-1:0] slot_q, slot_d;
  logic [STW-1:0] settle_q, settle_d;
  logic [SLOT_W-1:0] next_move_q, next_move_d;
  logic [7:0] curr_step_q, curr_step_d;
  logic done_prev_q, overflow_q, overflow_d, bad_code_q, bad_code_d;
  logic [SLOT_W-1:0] code, head, tail;
  logic [CW-1:0] count;
  logic [8:0] total;
  logic full, empty, push, pop, pop_tail, legal, cancel, load_ready;
  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_25mhz, .reset, .push, .push_data(code), .pop, .pop_tail,
    .head, .tail, .full, .empty, .count
  );
  // load FSM: capture a word, then shift out the MSB slot each cycle so slot SLOTS-1 queues first
  always_comb begin
    l_state_d = l_state_q;
    word_d = word_q;
    slot_d = slot_q;
    load_ready = l_state_q == L_IDLE && !bus.seq_complete && !reset;
    if (l_state_q == L_IDLE) begin
      if (bus.load_valid && load_ready) begin
        l_state_d = L_UNPACK;
        word_d = bus.load_moves;
        slot_d = SLW'(SLOTS - 1);
      end
    end else begin
      word_d = word_q << SLOT_W;
      slot_d = slot_q - SLW'(1);
      if (slot_q == '0) l_state_d = L_IDLE;
    end
  end
  // slot decode: padding vanishes, illegal codes flag, legal codes push or cancel the inverse tail
  always_comb begin
    code = word_q[SLOT_W*SLOTS-1 -: SLOT_W];
    legal = l_state_q == L_UNPACK && is_legal(code);
    cancel = CANCEL_EN && legal && !empty && tail == (code ^ SLOT_W'(1));
    push = legal && !cancel && !full;
    pop_tail = cancel;
    overflow_d = overflow_q || (legal && !cancel && full);
    bad_code_d = bad_code_q || (l_state_q == L_UNPACK && is_bad(code));
  end
  // dispatch FSM: issue, wait for a fresh move_done rise, settle, repeat until the queue drains
  always_comb begin
    d_state_d = d_state_q;
    next_move_d = next_move_q;
    curr_step_d = curr_step_q;
    settle_d = settle_q;
    pop = 1'b0;
    case (d_state_q)
      D_WAIT: if (bus.seq_complete && l_state_q == L_IDLE) begin
        d_state_d = empty ? D_DONE : D_ISSUE;
        next_move_d = empty ? next_move_q : head;
      end
      D_ISSUE: d_state_d = D_BUSY;
      D_BUSY: if (bus.move_done && !done_prev_q) begin
        pop = 1'b1;
        curr_step_d = curr_step_q + 8'(curr_step_q != 8'hFF);
        settle_d = '0;
        d_state_d = D_SETTLE;
      end
      D_SETTLE: begin
        settle_d = settle_q + STW'(1);
        if (settle_q == STW'(SETTLE_CYCLES - 1)) begin
          d_state_d = empty ? D_DONE : D_ISSUE;
          next_move_d = empty ? next_move_q : head;
        end
      end
      default: ;
    endcase
  end
  // state registers
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      l_state_q <= L_IDLE;
      d_state_q <= D_WAIT;
      word_q <= '0;
      slot_q <= '0;
      settle_q <= '0;
      next_move_q <= '0;
      curr_step_q <= '0;
      done_prev_q <= 1'b0;
      overflow_q <= 1'b0;
      bad_code_q <= 1'b0;
    end else begin
      l_state_q <= l_state_d;
      d_state_q <= d_state_d;
      word_q <= word_d;
      slot_q <= slot_d;
      settle_q <= settle_d;
      next_move_q <= next_move_d;
      curr_step_q <= curr_step_d;
      done_prev_q <= bus.move_done;
      overflow_q <= overflow_d;
      bad_code_q <= bad_code_d;
    end
  end
  // outputs; num_moves counts executed plus queued so it stays put while dispatching
  always_comb begin
    total = 9'(count) + 9'(curr_step_q);
    bus.num_moves = total[8] ? 8'hFF : total[7:0];
    bus.load_ready = load_ready;
    bus.next_move = next_move_q;
    bus.move_start = d_state_q == D_ISSUE;
    bus.curr_step = curr_step_q;
    bus.seq_done = d_state_q == D_DONE;
    bus.overflow = overflow_q;
    bus.bad_code = bad_code_q;
  end
endmodule

// File: tb/tb_move_dispatch_queue.sv
// tb_move_dispatch_queue: directed checks of load, dispatch handshake, counts, overflow, bad codes and cancellation
module tb_move_dispatch_queue;
  import move_dispatch_queue_pkg::*;
  localparam int SETTLE = 20;
  logic clock_25mhz = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0, n_fail = 0, cyc = 0, starts = 0;
  logic [3:0] expq[$];
  always #20 clock_25mhz = ~clock_25mhz;
  move_dispatch_queue_if bus();
  move_dispatch_queue #(.DEPTH(128), .SETTLE_CYCLES(SETTLE), .SLOTS(50)) dut (
    .clock_25mhz(clock_25mhz), .reset(reset), .bus(bus)
  );
  always @(posedge clock_25mhz) begin
    cyc++;
    if (bus.move_start) starts++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_moves = '0;
    bus.seq_complete = 1'b0;
    bus.move_done = 1'b0;
    repeat (2) @(negedge clock_25mhz);
    reset = 1'b0;
    @(negedge clock_25mhz);
  endtask
  task automatic load_word(input logic [199:0] w);
    int t = 0;
    while (!bus.load_ready && t < 100) begin
      @(negedge clock_25mhz);
      t++;
    end
    check("load_ready", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_moves = w;
    @(negedge clock_25mhz);
    bus.load_valid = 1'b0;
    check("ready_low_unpack", bus.load_ready, 0);
    repeat (52) @(negedge clock_25mhz);
  endtask
  task automatic wait_start(output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < 200 && !ok) begin
      if (bus.move_start) ok = 1'b1;
      else begin
        @(negedge clock_25mhz);
        t++;
      end
    end
  endtask
  task automatic wait_done();
    int t = 0;
    while (!bus.seq_done && t < 200) begin
      @(negedge clock_25mhz);
      t++;
    end
    check("seq_done", bus.seq_done, 1);
  endtask
  task automatic run_seq();
    bit ok;
    int done_cyc = 0;
    bus.seq_complete = 1'b1;
    foreach (expq[i]) begin
      wait_start(ok);
      check("move_start_seen", ok, 1);
      check("next_move", bus.next_move, expq[i]);
      if (i > 0) check("settle_gap", (cyc - done_cyc) >= SETTLE, 1);
      @(negedge clock_25mhz);
      check("start_one_cycle", bus.move_start, 0);
      repeat (2) @(negedge clock_25mhz);
      check("next_move_held", bus.next_move, expq[i]);
      bus.move_done = 1'b1;
      done_cyc = cyc;
      repeat (2) @(negedge clock_25mhz);
      bus.move_done = 1'b0;
    end
    wait_done();
    check("curr_step", bus.curr_step, expq.size());
  endtask
  initial begin
    bit ok;
    int s0;
    bus.load_valid = 1'b0;
    bus.load_moves = '0;
    bus.seq_complete = 1'b0;
    bus.move_done = 1'b0;
    repeat (2) @(negedge clock_25mhz);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_move_start", bus.move_start, 0);
    check("rst_num_moves", bus.num_moves, 0);
    check("rst_curr_step", bus.curr_step, 0);
    check("rst_seq_done", bus.seq_done, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_bad_code", bus.bad_code, 0);
    check("rst_next_move", bus.next_move, 0);
    do_reset();
    load_word(200'h23);
    check("rri_num_moves", bus.num_moves, 2);
    expq = '{4'd2, 4'd3};
    run_seq();
    check("rri_num_moves_after", bus.num_moves, 2);
    check("rri_bad_code", bus.bad_code, 0);
    check("rri_overflow", bus.overflow, 0);
    do_reset();
    load_word(200'h0);
    check("zero_num_moves", bus.num_moves, 0);
    s0 = starts;
    bus.seq_complete = 1'b1;
    wait_done();
    check("zero_no_start", starts - s0, 0);
    check("zero_bad_code", bus.bad_code, 0);
    do_reset();
    for (int k = 0; k < 3; k++) load_word({50{4'h2}});
    check("ovf_flag", bus.overflow, 1);
    check("ovf_num_moves", bus.num_moves, 128);
    do_reset();
    load_word(200'h2);
    bus.move_done = 1'b1;
    bus.seq_complete = 1'b1;
    wait_start(ok);
    check("held_start_seen", ok, 1);
    repeat (5) @(negedge clock_25mhz);
    check("held_no_pop", bus.curr_step, 0);
    check("held_not_done", bus.seq_done, 0);
    bus.move_done = 1'b0;
    repeat (2) @(negedge clock_25mhz);
    bus.move_done = 1'b1;
    @(negedge clock_25mhz);
    check("held_popped", bus.curr_step, 1);
    bus.move_done = 1'b0;
    wait_done();
    do_reset();
    load_word(200'h23);
    bus.seq_complete = 1'b1;
    wait_start(ok);
    check("busy_start_seen", ok, 1);
    @(negedge clock_25mhz);
    reset = 1'b1;
    @(negedge clock_25mhz);
    check("mid_rst_move_start", bus.move_start, 0);
    check("mid_rst_next_move", bus.next_move, 0);
    check("mid_rst_num_moves", bus.num_moves, 0);
    check("mid_rst_curr_step", bus.curr_step, 0);
    check("mid_rst_seq_done", bus.seq_done, 0);
    check("mid_rst_load_ready", bus.load_ready, 0);
    do_reset();
    load_word(200'hF4);
    check("bad_flag", bus.bad_code, 1);
    check("bad_num_moves", bus.num_moves, 1);
    expq = '{4'd4};
    run_seq();
    do_reset();
    load_word(200'h24536);
    check("cancel_bad_code", bus.bad_code, 0);
`ifdef MOVE_CANCEL_EN
    check("cancel_num_moves", bus.num_moves, 1);
    expq = '{4'd6};
`else
    check("cancel_num_moves", bus.num_moves, 5);
    expq = '{4'd2, 4'd4, 4'd5, 4'd3, 4'd6};
`endif
    run_seq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
